desroteamento: RTL
==================

// Module: desroteamento
// PURPOSE
//  Inverse of the 4:1 word router: accepts one WIDTH-bit input word plus a 2-bit destination.
//  Delivers the word to one of four registered output channels A..D.
//  Each channel has a one-word holding register with a valid/ack handshake toward its consumer.
//  The upstream valid/ready handshake stalls when the addressed channel is still occupied.
//  Sits between a single producer and four independent consumers.
// PARAMETERS
//  WIDTH  4  data width of Entrada and of each output channel A..D
// PORTS
//  clock     in   1      single clock; all state updates on its rising edge
//  reset     in   1      synchronous, active-high reset
//  Entrada   in   WIDTH  input word
//  SEL       in   2      destination: 00=A 01=B 10=C 11=D (ignored with DESROT_AUTOSEL_EN)
//  in_valid  in   1      producer presents Entrada/SEL this cycle
//  in_ready  out  1      block accepts this cycle; transfer = in_valid & in_ready
//  A,B,C,D   out  WIDTH  channel holding registers
//  valid     out  4      valid[i]=1: channel i (0=A..3=D) holds an unconsumed word
//  ack       in   4      consumer i takes word; effective only when valid[i]=1
//  cur_sel   out  2      destination in use this cycle (SEL, or internal pointer)
// BEHAVIOUR
//  - Reset (clock edge with reset=1): A..D=0, valid=0000, pointer=00. reset wins over any transfer/ack.
//  - Each channel is a 2-state FSM:
//    - EMPTY -> FULL on transfer to it.
//    - FULL -> EMPTY on ack without transfer.
//    - FULL -> FULL on ack and transfer in the same cycle (refill).
//  - in_ready = ~valid[cur_sel] | ack[cur_sel]. Combinational from ack and cur_sel; no comb path from in_valid.
//  - Latency: word transferred at edge k appears on channel cur_sel with valid=1 after edge k; 1 cycle.
//  - Data register is written only on transfer to that channel.
//    - Holds its value after ack (valid=0, data unchanged).
//    - Other channels are untouched.
//  - ack[i] while valid[i]=0: ignored, no state change.
//  - Acks on several channels in one cycle: all honoured independently.
//  - in_valid=1 with in_ready=0: no state change; producer must hold Entrada/SEL stable until accepted.
//  - All four channels full and no ack: in_ready=0 for any SEL; no word lost or overwritten.
//  - Reset mid-operation: pending words discarded; valid=0000 the following cycle.
// CONFIGURATION
//  DESROT_AUTOSEL_EN defined:
//    - SEL ignored.
//    - 2-bit pointer selects destination; cur_sel=pointer.
//    - Pointer increments mod 4 on each transfer (3 -> 0 wrap); holds on stall.
//    - Yields round-robin distribution A,B,C,D,A...
//  DESROT_AUTOSEL_EN undefined:
//    - cur_sel=SEL combinationally; no pointer register (optimised out).
//    - Port list identical in both builds.
// TESTING
//  1. reset=1 for 2 cycles -> A..D=0, valid=0000, in_ready=1.
//  2. Entrada=4'hA, SEL=10, in_valid=1 for 1 cycle -> next cycle C=4'hA, valid=0100; A, B, D unchanged.
//  3. C full, no ack, send SEL=10 Entrada=4'h5 -> in_ready=0, C stays 4'hA.
//     - Then ack[2]=1 with the same input -> in_ready=1 that cycle; next cycle C=4'h5, valid[2]=1.
//  4. Fill A..D with 1,2,3,4 -> valid=1111, in_ready=0 for all SEL.
//     - ack=1111 -> next cycle valid=0000; A..D still 1,2,3,4.
//  5. ack[1]=1 while valid[1]=0 -> no change.
//     - reset asserted while valid=1011 -> next cycle valid=0000, outputs 0.
//  6. DESROT_AUTOSEL_EN: send 5 words 1..5 with SEL=00 and acks always high:
//     - A,B,C,D receive 1,2,3,4; the 5th (5) goes to A.
//     - A stall (ack low) freezes cur_sel.

Source files
------------

// File: rtl/desroteamento.sv
// Demultiplexes one WIDTH-bit stream into four one-word holding channels A..D with valid/ack handshakes.
// Optional build macro DESROT_AUTOSEL_EN replaces SEL with an internal round-robin destination pointer.
module desroteamento #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] Entrada,
    input  logic [1:0]       SEL,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       valid,
    input  logic [3:0]       ack,
    output logic [1:0]       cur_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state      [4];
    chan_state_t      state_next [4];
    logic [WIDTH-1:0] data       [4];
    logic [3:0]       load;
    logic             transfer;

`ifdef DESROT_AUTOSEL_EN
    logic [1:0] ptr;
    logic       unused_sel;

    assign unused_sel = ^SEL;

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= 2'd0;
        else if (transfer)
            ptr <= ptr + 2'd1;
    end

    assign cur_sel = ptr;
`else
    assign cur_sel = SEL;
`endif

    // An ack on the addressed channel frees its slot in the same cycle, so refill needs no bubble.
    assign in_ready = ~valid[cur_sel] | ack[cur_sel];
    assign transfer = in_valid & in_ready;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        valid = '0;
        load  = '0;
        if (transfer)
            load[cur_sel] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid[i]      = (state[i] == FULL);
            state_next[i] = state[i];
            case (state[i])
                EMPTY:   if (load[i]) state_next[i] = FULL;
                FULL:    if (ack[i] && !load[i]) state_next[i] = EMPTY;
                default: state_next[i] = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (reset)
                state[i] <= EMPTY;
            else
                state[i] <= state_next[i];
        end
    end

    // NOTE: the data registers are reset too, because the channel outputs must read zero after reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (reset)
                data[i] <= '0;
            else if (load[i])
                data[i] <= Entrada;
        end
    end

    assign A = data[0];
    assign B = data[1];
    assign C = data[2];
    assign D = data[3];

endmodule
